// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready handshake between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // master: byte producer (the receiver); slave: byte consumer
  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, byte handshake, framing/overrun flags
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    rx,
  uart_rx_if.master out_if,
  output logic    frame_err,
  output logic    overrun,
  output logic    busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            rx_meta;
  logic            rx_s;

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;

  // Two-flop synchroniser; resets to the idle (high) line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: bit timing, deserialisation, output handshake and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= cnt + 1'b1;

      // Consumer took the byte; a load later in this block overrides the clear
      if (valid_q && out_if.out_ready) begin
        valid_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches
        S_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        // Counter was re-zeroed at mid start bit, so each full period lands at mid data bit
        S_DATA: begin
          if (cnt == CNT_END) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        // Leave at mid stop bit so a following start edge is caught with a single stop bit
        S_STOP: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              if (!valid_q || out_if.out_ready) begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        end

        // Line stuck low: wait for idle before hunting for another start bit
        S_BREAK: begin
          if (rx_s) begin
            cnt   <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
